hazard_stage_reg: RTL

Parametrised execute-to-memory pipeline register with built-in load-use hazard detection. Supports a configurable number of register read ports and a configurable load-use bubble count (1..3). Also provides branch flush, downstream hold, per-port ALU forwarding selects and a saturating stall counter. It sits between decode/execute and memory/writeback in the core pipeline and supersedes the fixed two-port, one-bubble stage register.

---
 rtl/hazard_stage_reg.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/hazard_stage_reg.sv
// Execute-to-memory stage register with load-use bubble insertion and per-port ALU forwarding selects.
// One-cycle latency; stall holds upstream during hazard bubbles or downstream hold, and flush overrides both.
module hazard_stage_reg #(
  parameter int DATA_W             = 32,
  parameter int IDX_W              = 4,
  parameter int NUM_RD             = 2,
  parameter int LOAD_BUBBLES       = 1,
  parameter int OP_W               = 4,
  parameter int ZERO_IDX_HARDWIRED = 1,
  parameter int CNT_W              = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [NUM_RD*IDX_W-1:0] in_rd_idx,
  input  logic [NUM_RD-1:0]       in_rd_en,
  input  logic [IDX_W-1:0]        in_wr_idx,
  input  logic                    in_reg_wr_en,
  input  logic                    in_is_load,
  input  logic                    in_is_store,
  input  logic [1:0]              in_mul_sel,
  input  logic [DATA_W-1:0]       in_alu_out,
  input  logic [DATA_W-1:0]       in_data2,
  input  logic [DATA_W-1:0]       in_pc,
  input  logic [OP_W-1:0]         in_inst_type,
  input  logic                    in_br_taken,
  input  logic                    flush,
  input  logic                    hold,
  output logic                    out_valid,
  output logic [IDX_W-1:0]        out_wr_idx,
  output logic                    out_reg_wr_en,
  output logic                    out_is_load,
  output logic                    out_is_store,
  output logic [1:0]              out_mul_sel,
  output logic [DATA_W-1:0]       out_alu_out,
  output logic [DATA_W-1:0]       out_data2,
  output logic [DATA_W-1:0]       out_pc,
  output logic [OP_W-1:0]         out_inst_type,
  output logic                    out_br_taken,
  output logic                    stall,
  output logic [NUM_RD-1:0]       fwd_sel,
  output logic [CNT_W-1:0]        stall_count
);

  typedef enum logic {RUN, BUBBLE} stateT;

  stateT             state, stateNext;
  logic [1:0]        cnt, cntNext;
  logic [IDX_W-1:0]  pendIdx, pendIdxNext;
  logic [NUM_RD-1:0] srcMatch;
  logic              hazard;
  logic              insertBubble;

  always_comb begin
    srcMatch = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      srcMatch[i] = in_rd_en[i] && (in_rd_idx[i*IDX_W +: IDX_W] == out_wr_idx) &&
                    !((ZERO_IDX_HARDWIRED != 0) && (out_wr_idx == '0));
    end
  end

  always_comb begin
    stateNext    = state;
    cntNext      = cnt;
    pendIdxNext  = pendIdx;
    hazard       = (state == RUN) && in_valid && out_valid && out_reg_wr_en && out_is_load &&
                   (|srcMatch);
    insertBubble = hazard || ((state == BUBBLE) && (cnt != 2'd0));
    stall        = !flush && (hold || insertBubble);
    fwd_sel      = flush ? '0 : (srcMatch & {NUM_RD{out_valid && out_reg_wr_en && !out_is_load}});
    if (flush) begin
      stateNext = RUN;
      cntNext   = 2'd0;
    end else if (!hold) begin
      if (hazard) begin
        pendIdxNext = out_wr_idx;
        // A single bubble needs no extra state: the bubble itself clears the hazard.
        if (LOAD_BUBBLES > 1) begin
          stateNext = BUBBLE;
          cntNext   = 2'(LOAD_BUBBLES - 1);
        end
      end else if (state == BUBBLE) begin
        if (cnt != 2'd0) cntNext = cnt - 2'd1;
        else stateNext = RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RUN;
      cnt     <= 2'd0;
      pendIdx <= '0;
    end else begin
      state   <= stateNext;
      cnt     <= cntNext;
      pendIdx <= pendIdxNext;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid     <= 1'b0;
      out_wr_idx    <= '0;
      out_reg_wr_en <= 1'b0;
      out_is_load   <= 1'b0;
      out_is_store  <= 1'b0;
      out_mul_sel   <= '0;
      out_alu_out   <= '0;
      out_data2     <= '0;
      out_pc        <= '0;
      out_inst_type <= '0;
      out_br_taken  <= 1'b0;
      stall_count   <= '0;
    end else if (flush || !hold) begin
      out_wr_idx    <= in_wr_idx;
      out_mul_sel   <= in_mul_sel;
      out_alu_out   <= in_alu_out;
      out_data2     <= in_data2;
      out_pc        <= in_pc;
      out_inst_type <= in_inst_type;
      out_br_taken  <= in_br_taken;
      if (flush || insertBubble) begin
        out_valid     <= 1'b0;
        out_reg_wr_en <= 1'b0;
        out_is_load   <= 1'b0;
        out_is_store  <= 1'b0;
      end else begin
        out_valid     <= in_valid;
        out_reg_wr_en <= in_valid && in_reg_wr_en;
        out_is_load   <= in_valid && in_is_load;
        out_is_store  <= in_valid && in_is_store;
      end
      if (!flush && insertBubble && (stall_count != '1)) stall_count <= stall_count + CNT_W'(1);
    end
  end

  // A bubble sequence is only entered from a real load destination, never a hardwired zero.
  assert property (@(posedge clk) disable iff (reset)
    ((state == BUBBLE) && (ZERO_IDX_HARDWIRED != 0)) |-> (pendIdx != '0));

endmodule
